// File: rtl/simplebus_leader_arbiter.sv
// rtl/simplebus_leader_arbiter.sv - round-robin arbiter and transaction sequencer for a simplebus leader port
// Optional feature macro: SB_ARB_TIMEOUT_EN (read-wait timeout that aborts the transaction with err=1).
module simplebus_leader_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_we,
  input  logic [16*N_REQ-1:0]  req_addr,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 bus_start,
  output logic                 bus_read,
  output logic [7:0]           bus_address,
  output logic [7:0]           bus_data_out,
  output logic                 bus_data_oe,
  input  logic [7:0]           bus_data_in,
  output logic                 bus_dv_out,
  output logic                 bus_dv_oe,
  input  logic                 bus_dv_in
);

  localparam int IW = $clog2(N_REQ);

  // Parameter sanity: the index width and the 8-bit wait counter bound these.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;

`ifdef SB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Round-robin pick: lowest set bit above rr_ptr, else lowest set bit overall.
  logic            hi_found, lo_found;
  logic [IW-1:0]   hi_idx, lo_idx;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  // Arbitration scan; descending loop leaves the lowest qualifying index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(j);
        if (IW'(j) > rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(j);
        end
      end
    end
    pick_valid = lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Selected requester's fields, muxed with constant slices.
  logic            sel_we;
  logic [15:0]     sel_addr;
  logic [7:0]      sel_wdata;

  // Field mux for the winning requester.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (IW'(j) == pick_idx) begin
        sel_we    = req_we[j];
        sel_addr  = req_addr[16*j +: 16];
        sel_wdata = req_wdata[8*j +: 8];
      end
    end
  end

  // State register and latched-request datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IW'(N_REQ - 1);
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef SB_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef SB_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and datapath updates; the request is captured only in IDLE.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef SB_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          idx_d   = pick_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = S_ADDR_HI;
`ifdef SB_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_ADDR_HI: state_d = S_ADDR_LO;
      S_ADDR_LO: begin
        if (we_q) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_RD_WAIT;
`ifdef SB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RD_WAIT: begin
        if (bus_dv_in) begin
          rdata_d = bus_data_in;
          state_d = S_FIN;
`ifdef SB_ARB_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_WR_DATA: state_d = S_FIN;
      S_FIN: begin
        rr_ptr_d = idx_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    done         = '0;
    err          = 1'b0;
    rdata        = rdata_q;
    busy         = (state_q != S_IDLE);
    bus_start    = 1'b0;
    bus_read     = 1'b0;
    bus_address  = '0;
    bus_data_out = '0;
    bus_data_oe  = 1'b0;
    bus_dv_out   = 1'b0;
    bus_dv_oe    = 1'b0;
    case (state_q)
      S_ADDR_HI: begin
        bus_start   = 1'b1;
        bus_address = addr_q[15:8];
      end
      S_ADDR_LO: begin
        bus_address = addr_q[7:0];
        bus_read    = ~we_q;
      end
      S_WR_DATA: begin
        bus_data_oe  = 1'b1;
        bus_data_out = wdata_q;
        bus_dv_oe    = 1'b1;
        bus_dv_out   = 1'b1;
      end
      S_FIN: begin
        for (int j = 0; j < N_REQ; j++) begin
          done[j] = (idx_q == IW'(j));
        end
`ifdef SB_ARB_TIMEOUT_EN
        err = err_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simplebus_leader_arbiter.sv
// tb/tb_simplebus_leader_arbiter.sv - scoreboard bench with follower memory and round-robin reference model
module tb_simplebus_leader_arbiter;
  localparam int N  = 4;
  localparam int TO = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [16*N-1:0] req_addr = '0;
  logic [8*N-1:0]  req_wdata = '0;
  logic [N-1:0]    done;
  logic            err;
  logic [7:0]      rdata;
  logic            busy, bus_start, bus_read, bus_data_oe, bus_dv_out, bus_dv_oe;
  logic [7:0]      bus_address, bus_data_out;
  logic [7:0]      bus_data_in;
  logic            bus_dv_in;
  logic [7:0]      f_data = '0;
  logic            f_dv = 1'b0;

  assign bus_data_in = bus_data_oe ? bus_data_out : f_data;
  assign bus_dv_in   = bus_dv_oe ? bus_dv_out : f_dv;

  simplebus_leader_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .bus_start(bus_start), .bus_read(bus_read), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
    .bus_dv_out(bus_dv_out), .bus_dv_oe(bus_dv_oe), .bus_dv_in(bus_dv_in)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    bit          to;
    int          start;
  } exp_t;

  exp_t eq[$];
  exp_t cur;
  exp_t got;

  // Reference model state: who was served last, what memory should hold, last read value.
  int              last_grant = N - 1;
  logic [7:0]      rmem [logic [15:0]];
  logic [7:0]      last_rd = '0;
  int              force_w = -1;  // -1 random, 255 never respond
  int              last_w = 0;

  // Snapshot of the previous negedge = values the DUT sampled at the grant edge.
  logic [N-1:0]    req_s = '0, we_s = '0;
  logic [16*N-1:0] addr_s = '0;
  logic [8*N-1:0]  wdata_s = '0;
  logic            busy_s = 1'b0;
  int              ph = 0;
  int              win;
  int              cand;

  // Predictor: on each bus_start decide the winner from the rules and push the expected result.
  always @(negedge clock) begin
    if (reset) begin
      eq.delete();
      last_grant = N - 1;
      last_rd = '0;
      ph = 0;
    end else begin
      if (ph == 1) begin
        chk("addr_lo", {24'h0, bus_address}, {24'h0, cur.addr[7:0]});
        chk("read_flag", {31'h0, bus_read}, {31'h0, ~cur.we});
        ph = cur.we ? 2 : 0;
      end else if (ph == 2) begin
        chk("wr_enables", {29'h0, bus_data_oe, bus_dv_oe, bus_dv_out}, 32'h7);
        chk("wr_data", {24'h0, bus_data_out}, {24'h0, cur.wdata});
        ph = 0;
      end
      if (bus_start) begin
        chk("idle_before_start", {31'h0, busy_s}, 32'h0);
        win = -1;
        for (int k = 1; k <= N; k++) begin
          cand = (last_grant + k) % N;
          if (win < 0 && req_s[cand]) win = cand;
        end
        if (win < 0) begin
          chk("grant_without_req", 32'h1, 32'h0);
        end else begin
          cur.idx   = win;
          cur.we    = we_s[win];
          cur.addr  = addr_s[16*win +: 16];
          cur.wdata = wdata_s[8*win +: 8];
          cur.to    = (!cur.we && force_w == 255);
          cur.start = cyc;
          if (cur.we) begin
            rmem[cur.addr] = cur.wdata;
            cur.rdata = last_rd;
          end else if (cur.to) begin
            cur.rdata = last_rd;
          end else begin
            cur.rdata = rmem.exists(cur.addr) ? rmem[cur.addr] : 8'h00;
            last_rd = cur.rdata;
          end
          eq.push_back(cur);
          last_grant = win;
          chk("addr_hi", {24'h0, bus_address}, {24'h0, cur.addr[15:8]});
          chk("start_read_low", {31'h0, bus_read}, 32'h0);
          ph = 1;
        end
      end else if (!busy) begin
        chk("idle_outputs", {6'h0, done, err, bus_start, bus_read, bus_address,
                             bus_data_out, bus_data_oe, bus_dv_oe, bus_dv_out}, 32'h0);
      end
    end
    req_s = req; we_s = req_we; addr_s = req_addr; wdata_s = req_wdata; busy_s = busy;
  end

  // Monitor: pop and compare whenever the DUT pulses done.
  always @(negedge clock) begin
    if (!reset) begin
      if (done != '0) begin
        if (eq.size() == 0) begin
          chk("spurious_done", {28'h0, done}, 32'h0);
        end else begin
          got = eq.pop_front();
          chk("done_onehot", {28'h0, done}, 32'h1 << got.idx);
          chk("err", {31'h0, err}, {31'h0, got.to});
          chk("rdata", {24'h0, rdata}, {24'h0, got.rdata});
          chk("latency", cyc - got.start,
              got.we ? 3 : (got.to ? 2 + TO : 3 + last_w));
        end
      end else begin
        chk("err_without_done", {31'h0, err}, 32'h0);
      end
    end
  end

  // Follower memory: decodes the two address phases, stores writes, answers reads after W cycles.
  logic [7:0]   fmem [logic [15:0]];
  logic [7:0]   f_hi = '0, f_lo = '0;
  int           fph = 0, fw = 0, fk = 0;
  always @(negedge clock) begin
    if (reset) begin
      fph = 0; f_dv = 1'b0; f_data = '0;
    end else begin
      if (bus_dv_oe && bus_dv_out) fmem[{f_hi, f_lo}] = bus_data_out;
      case (fph)
        0: if (bus_start) begin f_hi = bus_address; fph = 1; end
        1: begin
          f_lo = bus_address;
          if (bus_read) begin
            fw = (force_w >= 0) ? force_w : $urandom_range(0, 5);
            last_w = fw; fk = 0; fph = 2;
          end else begin
            fph = 0;
          end
        end
        default: begin
          if (done != '0) begin
            f_dv = 1'b0; fph = 0;
          end else if (fk == fw) begin
            f_dv = 1'b1;
            f_data = fmem.exists({f_hi, f_lo}) ? fmem[{f_hi, f_lo}] : 8'h00;
          end else begin
            fk++;
          end
        end
      endcase
    end
  end

  task automatic set_req(input int i, input bit we, input logic [15:0] a, input logic [7:0] d);
    req_we[i] = we;
    req_addr[16*i +: 16] = a;
    req_wdata[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  // Drop each request on its done pulse until everything is idle.
  task automatic wait_quiet(input int limit);
    int n;
    n = 0;
    while (n < limit && !(req == '0 && !busy)) begin
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
      n++;
    end
    if (n >= limit) chk("quiesce_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_state", {14'h0, done, err, busy, rdata, bus_address}, 32'h0);

    // All four writing, re-raised immediately: grants must rotate 0,1,2,3,0,...
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'h0400 + 16'(i), 8'hD0 + 8'(i));
    for (int c = 0; c < 2500; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && (c < 40 || $urandom_range(0, 3) == 0)) begin
          set_req(i, (c < 40) ? 1'b1 : 1'($urandom_range(0, 1)),
                  16'h0400 | (16'($urandom_range(0, 1)) << 8) | 16'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)));
        end
      end
    end
    wait_quiet(300);

    // Grant is immune to req/addr changes after ADDR_HI.
    @(posedge clock); #1;
    set_req(2, 1'b1, 16'h1234, 8'h5A);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!bus_start && n < 20);
    chk("grant_seen", {31'h0, bus_start}, 32'h1);
    req[2] = 1'b0;
    req_addr[16*2 +: 16] = 16'hFFFF;
    req_wdata[8*2 +: 8] = 8'h00;
    wait_quiet(50);
    force_w = 3;
    set_req(2, 1'b0, 16'h1234, 8'h00);
    wait_quiet(50);

    // Reset during RD_WAIT: everything clears, no done afterwards.
    force_w = 20;
    set_req(1, 1'b0, 16'h0400, 8'h00);
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!bus_read && n < 20);
    chk("read_phase_seen", {31'h0, bus_read}, 32'h1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1; req[1] = 1'b0;
    @(posedge clock); #1;
    chk("reset_mid_txn", {4'h0, done, err, busy, bus_start, bus_read, bus_address,
                          bus_data_out, bus_data_oe, bus_dv_oe}, 32'h0);
    chk("reset_mid_rdata", {24'h0, rdata}, 32'h0);
    reset = 1'b0;
    force_w = -1;
    repeat (30) @(posedge clock);
    #1;
    set_req(0, 1'b0, 16'h1234, 8'h00);
    wait_quiet(50);

`ifdef SB_ARB_TIMEOUT_EN
    force_w = 255;
    set_req(3, 1'b0, 16'h0401, 8'h00);
    wait_quiet(100);
    force_w = -1;
`endif

    repeat (5) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
